// File: rtl/peak_counter_readout.sv
// Readout sequencer for the peak counter PISO: loads the shift register once, then streams
// a framed byte sequence (header, overflow flags, count bytes) over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start_in
// LOAD  | PISO load pulse, overflow flags captured, header staged into the output register
// HDR   | header byte presented
// OVF   | overflow byte cnt presented (LSB byte first)
// DATA  | count byte cnt presented (cnt = count bytes taken from the PISO so far)
// DONE  | one-cycle completion pulse, start_in ignored
module peak_counter_readout #(
  parameter int         CNTR_DEPTH  = 24,
  parameter int         CNTR_WIDTH  = 8,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic [CNTR_WIDTH-1:0] count_in,
  input  logic [CNTR_DEPTH-1:0] overflow_in,
  output logic                  sreg_load_en,
  output logic                  sreg_shift_en,
  output logic [7:0]            tx_data_out,
  output logic                  tx_vld_out,
  input  logic                  tx_rdy_in,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int NOVF = (CNTR_DEPTH + 7) / 8;
  localparam int CW   = $clog2(CNTR_DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNTR_DEPTH);
  localparam logic [CW-1:0] OVF_LAST = CW'(NOVF - 1);

  if (CNTR_WIDTH != 8) begin : g_width_check
    $error("peak_counter_readout supports CNTR_WIDTH == 8 only");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HDR, S_OVF, S_DATA, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [CNTR_DEPTH-1:0] ovf_cap;
  logic [NOVF*8-1:0]   ovf_pad;
  logic [CW-1:0]       ovf_idx;
  logic [7:0]          ovf_byte;
  logic                take;

  // Output register may be refilled when it is empty or its byte transfers this edge.
  assign take = ~tx_vld_out | tx_rdy_in;

  always_comb begin
    ovf_pad = '0;
    ovf_pad[CNTR_DEPTH-1:0] = ovf_cap;
    ovf_idx = (state == S_OVF) ? cnt + 1'b1 : '0;
    ovf_byte = 8'(ovf_pad >> {ovf_idx, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_in) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_HDR;
      S_HDR:  if (take) state_nxt = S_OVF;
      S_OVF:  if (take && cnt == OVF_LAST) state_nxt = S_DATA;
      S_DATA: if (take && cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sreg_load_en  = (state == S_LOAD);
    sreg_shift_en = take & (((state == S_OVF) && (cnt == OVF_LAST)) ||
                            ((state == S_DATA) && (cnt != CNT_LAST)));
    busy_out      = (state == S_LOAD) || (state == S_HDR) ||
                    (state == S_OVF)  || (state == S_DATA);
    done_out      = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cap     <= '0;
      cnt         <= '0;
      tx_data_out <= '0;
      tx_vld_out  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          ovf_cap     <= overflow_in;
          tx_data_out <= HEADER_BYTE;
          tx_vld_out  <= 1'b1;
          cnt         <= '0;
        end
        S_HDR: if (take) tx_data_out <= ovf_byte;
        S_OVF: if (take) begin
          if (cnt == OVF_LAST) begin
            tx_data_out <= 8'(count_in);
            cnt         <= CW'(1);
          end else begin
            tx_data_out <= ovf_byte;
            cnt         <= cnt + 1'b1;
          end
        end
        S_DATA: if (take) begin
          if (cnt == CNT_LAST) begin
            tx_vld_out <= 1'b0;
          end else begin
            tx_data_out <= 8'(count_in);
            cnt         <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_counter_readout.sv
// Bench for peak_counter_readout: PISO models feed two instances (depth 24 and 5); a
// negedge monitor pops expected frame bytes from a queue on every accepted transfer.
module tb_peak_counter_readout;

  localparam int DA = 24;
  localparam int DB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rdy;
  logic          start_a, load_a, shift_a, vld_a, busy_a, done_a;
  logic [7:0]    count_a, data_a;
  logic [DA-1:0] ovf_a;
  logic          start_b, load_b, shift_b, vld_b, busy_b, done_b;
  logic [7:0]    count_b, data_b;
  logic [DB-1:0] ovf_b;

  peak_counter_readout #(.CNTR_DEPTH(DA), .CNTR_WIDTH(8), .HEADER_BYTE(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .start_in(start_a), .count_in(count_a), .overflow_in(ovf_a),
    .sreg_load_en(load_a), .sreg_shift_en(shift_a), .tx_data_out(data_a),
    .tx_vld_out(vld_a), .tx_rdy_in(rdy), .busy_out(busy_a), .done_out(done_a));

  peak_counter_readout #(.CNTR_DEPTH(DB), .CNTR_WIDTH(8), .HEADER_BYTE(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .start_in(start_b), .count_in(count_b), .overflow_in(ovf_b),
    .sreg_load_en(load_b), .sreg_shift_en(shift_b), .tx_data_out(data_b),
    .tx_vld_out(vld_b), .tx_rdy_in(rdy), .busy_out(busy_b), .done_out(done_b));

  // PISO models: load counts on load pulse, advance one byte per shift pulse.
  logic [7:0] piso_a [DA];
  logic [7:0] piso_b [DB];
  assign count_a = piso_a[0];
  assign count_b = piso_b[0];

  always @(posedge clk) begin
    if (load_a) for (int i = 0; i < DA; i++) piso_a[i] <= 8'(i + 1);
    else if (shift_a) begin
      for (int i = 0; i < DA - 1; i++) piso_a[i] <= piso_a[i+1];
      piso_a[DA-1] <= 8'h00;
    end
    if (load_b) for (int i = 0; i < DB; i++) piso_b[i] <= 8'(i + 7);
    else if (shift_b) begin
      for (int i = 0; i < DB - 1; i++) piso_b[i] <= piso_b[i+1];
      piso_b[DB-1] <= 8'h00;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int cyc = 0;
  int acc_a, loads_a, shifts_a, first_acc_a, last_acc_a, done_cyc_a;
  int acc_b, loads_b, shifts_b, done_cyc_b;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data;
  logic [7:0] e_a, e_b;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_hold_vld", vld_a, 1);
        check("stall_hold_data", data_a, stall_data);
      end
      if (vld_a && !rdy) check("stall_no_shift", shift_a, 0);
      if (load_a || shift_a) check("load_shift_exclusive", load_a & shift_a, 0);
      if (load_a) loads_a++;
      if (shift_a) shifts_a++;
      if (vld_a && rdy) begin
        if (exp_a.size() == 0) check("unexpected_byte_a", data_a, 32'hFFFF_FFFF);
        else begin
          e_a = exp_a.pop_front();
          check("byte_a", data_a, e_a);
        end
        if (acc_a == 0) first_acc_a = cyc;
        last_acc_a = cyc;
        acc_a++;
      end
      if (done_a) done_cyc_a = cyc;
      stall_prev = vld_a && !rdy;
      stall_data = data_a;

      if (load_b) loads_b++;
      if (shift_b) shifts_b++;
      if (vld_b && rdy) begin
        if (exp_b.size() == 0) check("unexpected_byte_b", data_b, 32'hFFFF_FFFF);
        else begin
          e_b = exp_b.pop_front();
          check("byte_b", data_b, e_b);
        end
        acc_b++;
      end
      if (done_b) done_cyc_b = cyc;
    end
  end

  // Ready driver: always high, or high one cycle in three.
  int rdy_mode = 0;
  int rdy_phase = 0;
  initial begin
    rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy = (rdy_mode == 0) ? 1'b1 : (rdy_phase == 0);
      rdy_phase = (rdy_phase + 1) % 3;
    end
  end

  task automatic clr_a();
    exp_a.delete();
    acc_a = 0; loads_a = 0; shifts_a = 0;
    first_acc_a = -1; last_acc_a = -1; done_cyc_a = -1;
  endtask

  task automatic push_frame_a();
    exp_a.push_back(8'hA5);
    exp_a.push_back(8'h01);
    exp_a.push_back(8'h00);
    exp_a.push_back(8'h80);
    for (int i = 1; i <= DA; i++) exp_a.push_back(8'(i));
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_acc_a(int n, int lim);
    int k = 0;
    while (acc_a < n && k < lim) begin @(posedge clk); k++; end
    check("wait_acc_a_timeout", acc_a >= n, 1);
  endtask

  task automatic wait_done_a(int lim);
    int k = 0;
    while (done_cyc_a < 0 && k < lim) begin @(posedge clk); k++; end
    check("wait_done_a_timeout", done_cyc_a >= 0, 1);
  endtask

  task automatic check_frame_a(string tag);
    check({tag, "_queue_empty"}, exp_a.size(), 0);
    check({tag, "_bytes"}, acc_a, 28);
    check({tag, "_loads"}, loads_a, 1);
    check({tag, "_shifts"}, shifts_a, DA);
    check({tag, "_done_delay"}, done_cyc_a - last_acc_a, 1);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b1; start_b = 1'b0;
    ovf_a = 24'h800001; ovf_b = 5'b10011;
    clr_a();
    acc_b = 0; loads_b = 0; shifts_b = 0; done_cyc_b = -1;

    // Reset held with start high: everything stays quiet.
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_load", load_a, 0);
      check("rst_shift", shift_a, 0);
      check("rst_vld", vld_a, 0);
      check("rst_data", data_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
    end
    start_a = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Nominal frame, ready always high.
    clr_a(); push_frame_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    check("load_pulse", load_a, 1);
    check("busy_on_load", busy_a, 1);
    @(posedge clk); #1;
    check("hdr_vld", vld_a, 1);
    check("hdr_data", data_a, 8'hA5);
    wait_done_a(200);
    #1 check("done_one_cycle", done_a, 0);
    check_frame_a("nominal");
    check("nominal_back_to_back", last_acc_a - first_acc_a, 27);

    // Backpressure: identical frame, ready one cycle in three.
    repeat (2) @(posedge clk);
    rdy_mode = 1;
    clr_a(); push_frame_a();
    pulse_start_a();
    wait_done_a(400);
    check_frame_a("backpressure");
    rdy_mode = 0;

    // Start pulses during a frame are ignored.
    repeat (3) @(posedge clk);
    clr_a(); push_frame_a();
    pulse_start_a();
    wait_acc_a(5, 100);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_acc_a(20, 100);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done_a(200);
    repeat (10) @(posedge clk);
    check_frame_a("start_ignored");
    check("start_ignored_idle_vld", vld_a, 0);

    // Reset after byte 10 is accepted, then a fresh complete frame.
    clr_a(); push_frame_a();
    pulse_start_a();
    wait_acc_a(10, 100);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_vld", vld_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_shift", shift_a, 0);
    check("midrst_load", load_a, 0);
    rst = 1'b0;
    clr_a(); push_frame_a();
    pulse_start_a();
    wait_done_a(200);
    check_frame_a("after_reset");

    // Depth 5 instance: single overflow byte with unused bits zero.
    exp_b.delete();
    exp_b.push_back(8'hA5);
    exp_b.push_back(8'h13);
    for (int i = 7; i <= 11; i++) exp_b.push_back(8'(i));
    acc_b = 0; loads_b = 0; shifts_b = 0; done_cyc_b = -1;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    begin
      int k = 0;
      while (done_cyc_b < 0 && k < 100) begin @(posedge clk); k++; end
    end
    check("depth5_done_seen", done_cyc_b >= 0, 1);
    check("depth5_queue_empty", exp_b.size(), 0);
    check("depth5_bytes", acc_b, 7);
    check("depth5_loads", loads_b, 1);
    check("depth5_shifts", shifts_b, DB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
